// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a word-indexed synchronous data memory.
// Sub-word stores become read-modify-write; addresses beyond the memory depth complete with an error.
//   state     | meaning
//   IDLE      | arbitrate, grant, issue the first memory cycle
//   RD_RESP   | return load data registered by the memory
//   RMW_MERGE | write back the merged word of a partial store
//   WR_RESP   | acknowledge store, empty store or range error
module dmem_arbiter #(
  parameter int ADDR_BITS = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ0,
  input  logic        WE0,
  input  logic [31:0] ADDR0,
  input  logic [31:0] WDATA0,
  input  logic [3:0]  BE0,
  output logic        GNT0,
  output logic        ACK0,
  output logic [31:0] RDATA0,
  output logic        ERR0,
  input  logic        REQ1,
  input  logic        WE1,
  input  logic [31:0] ADDR1,
  input  logic [31:0] WDATA1,
  input  logic [3:0]  BE1,
  output logic        GNT1,
  output logic        ACK1,
  output logic [31:0] RDATA1,
  output logic        ERR1,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA
);

  typedef enum logic [1:0] {IDLE, RD_RESP, RMW_MERGE, WR_RESP} state_t;

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic                 port_q, port_d;
  logic                 err_q, err_d;
  logic [ADDR_BITS-1:0] widx_q, widx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;

  logic                 any_req, win, req_we, req_oor;
  logic [31:0]          req_addr, req_wdata, merged;
  logic [3:0]           req_be;
  logic [ADDR_BITS-1:0] req_widx;
  logic                 gnt, ack, err;
  logic [31:0]          rdata;
  logic                 unused_addr_lsbs;

  always_comb begin
    any_req   = REQ0 | REQ1;
    // On conflict the port that did not win last time goes; otherwise the lone requester.
    win       = (REQ0 & REQ1) ? ~last_q : REQ1;
    req_we    = win ? WE1 : WE0;
    req_addr  = win ? ADDR1 : ADDR0;
    req_wdata = win ? WDATA1 : WDATA0;
    req_be    = win ? BE1 : BE0;
    req_oor   = |req_addr[31:ADDR_BITS+2];
    req_widx  = req_addr[ADDR_BITS+1:2];
  end

  assign unused_addr_lsbs = ^req_addr[1:0];

  always_comb begin
    merged = '0;
    for (int k = 0; k < 4; k++)
      merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : MEM_RDATA[8*k +: 8];
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    port_d    = port_q;
    err_d     = err_q;
    widx_d    = widx_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    gnt       = 1'b0;
    ack       = 1'b0;
    err       = 1'b0;
    rdata     = '0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt     = 1'b1;
          last_d  = win;
          port_d  = win;
          widx_d  = req_widx;
          wdata_d = req_wdata;
          be_d    = req_be;
          err_d   = req_oor;
          if (req_oor) begin
            state_d = WR_RESP;
          end else if (!req_we) begin
            MEM_ADDR = 32'(req_widx);
            state_d  = RD_RESP;
          end else if (req_be == 4'hF) begin
            MEM_WE    = 1'b1;
            MEM_ADDR  = 32'(req_widx);
            MEM_WDATA = req_wdata;
            state_d   = WR_RESP;
          end else if (req_be == 4'h0) begin
            state_d = WR_RESP;
          end else begin
            MEM_ADDR = 32'(req_widx);
            state_d  = RMW_MERGE;
          end
        end
      end
      RD_RESP: begin
        ack     = 1'b1;
        rdata   = MEM_RDATA;
        state_d = IDLE;
      end
      RMW_MERGE: begin
        MEM_WE    = 1'b1;
        MEM_ADDR  = 32'(widx_q);
        MEM_WDATA = merged;
        state_d   = WR_RESP;
      end
      WR_RESP: begin
        ack     = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    GNT0   = gnt & ~win;
    GNT1   = gnt & win;
    ACK0   = ack & ~port_q;
    ACK1   = ack & port_q;
    ERR0   = err & ~port_q;
    ERR1   = err & port_q;
    RDATA0 = port_q ? '0 : rdata;
    RDATA1 = port_q ? rdata : '0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      err_q   <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      err_q   <= err_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: transaction-level reference model plus a 64-word memory model.
module tb_dmem_arbiter;

  logic        CLK, RESET;
  logic        tb_req[2], tb_we[2];
  logic [31:0] tb_addr[2], tb_wdata[2];
  logic [3:0]  tb_be[2];
  logic        GNT0, GNT1, ACK0, ACK1, ERR0, ERR1, MEM_WE;
  logic [31:0] RDATA0, RDATA1, MEM_ADDR, MEM_WDATA, MEM_RDATA;

  dmem_arbiter #(.ADDR_BITS(6)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(tb_req[0]), .WE0(tb_we[0]), .ADDR0(tb_addr[0]), .WDATA0(tb_wdata[0]), .BE0(tb_be[0]),
    .GNT0(GNT0), .ACK0(ACK0), .RDATA0(RDATA0), .ERR0(ERR0),
    .REQ1(tb_req[1]), .WE1(tb_we[1]), .ADDR1(tb_addr[1]), .WDATA1(tb_wdata[1]), .BE1(tb_be[1]),
    .GNT1(GNT1), .ACK1(ACK1), .RDATA1(RDATA1), .ERR1(ERR1),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // memory the arbiter drives
  logic [31:0] mem_arr[64];
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= '0;
      MEM_RDATA <= '0;
    end else if (MEM_WE) begin
      mem_arr[MEM_ADDR[5:0]] <= MEM_WDATA;
    end else begin
      MEM_RDATA <= mem_arr[MEM_ADDR[5:0]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: transaction view of the arbiter
  logic [31:0] shadow[64];
  int          cyc, next_idle, ack_cyc, wr_cyc, m_last, ack_port;
  logic [31:0] ack_rdata, wr_data, wr_idx;
  logic        ack_err;
  logic        granted[2], acked[2], obs_err[2];
  logic [31:0] obs_rdata[2];
  logic [1:0]  e_gnt, e_ack, e_err;
  logic [31:0] e_rdata[2];
  logic        e_we;
  logic [31:0] e_addr, e_wd;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    next_idle = cyc;
    ack_cyc   = -1;
    wr_cyc    = -1;
    m_last    = 1;
  endtask

  task automatic model_accept(input int w);
    logic [31:0] a, d, m;
    logic [3:0]  b;
    int          idx, lat;
    a = tb_addr[w]; d = tb_wdata[w]; b = tb_be[w];
    idx = int'((a / 4) % 64);
    ack_rdata = '0;
    ack_err   = 1'b0;
    lat       = 1;
    if (a >= 32'd256) begin
      ack_err = 1'b1;
    end else if (!tb_we[w]) begin
      e_addr    = 32'(idx);
      ack_rdata = shadow[idx];
    end else if (b == 4'hF) begin
      e_we = 1'b1; e_addr = 32'(idx); e_wd = d;
      shadow[idx] = d;
    end else if (b != 4'h0) begin
      e_addr = 32'(idx);
      m = shadow[idx];
      for (int k = 0; k < 4; k++) if (b[k]) m[8*k +: 8] = d[8*k +: 8];
      shadow[idx] = m;
      wr_cyc  = cyc + 1;
      wr_idx  = 32'(idx);
      wr_data = m;
      lat     = 2;
    end
    ack_cyc   = cyc + lat;
    ack_port  = w;
    next_idle = cyc + lat + 1;
    m_last    = w;
  endtask

  task automatic tick();
    int w;
    granted[0] = 1'b0; granted[1] = 1'b0;
    acked[0] = 1'b0;   acked[1] = 1'b0;
    @(negedge CLK);
    e_gnt = '0; e_ack = '0; e_err = '0;
    e_rdata[0] = '0; e_rdata[1] = '0;
    e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (wr_cyc == cyc) begin
      e_we = 1'b1; e_addr = wr_idx; e_wd = wr_data;
    end
    if (ack_cyc == cyc) begin
      e_ack[ack_port]   = 1'b1;
      e_err[ack_port]   = ack_err;
      e_rdata[ack_port] = ack_rdata;
    end
    if (!RESET && cyc >= next_idle && (tb_req[0] || tb_req[1])) begin
      w = (tb_req[0] && tb_req[1]) ? 1 - m_last : (tb_req[0] ? 0 : 1);
      e_gnt[w] = 1'b1;
      model_accept(w);
    end
    chk("gnt0", 32'(GNT0), 32'(e_gnt[0]));
    chk("gnt1", 32'(GNT1), 32'(e_gnt[1]));
    chk("ack0", 32'(ACK0), 32'(e_ack[0]));
    chk("ack1", 32'(ACK1), 32'(e_ack[1]));
    chk("err0", 32'(ERR0), 32'(e_err[0]));
    chk("err1", 32'(ERR1), 32'(e_err[1]));
    chk("rdata0", RDATA0, e_rdata[0]);
    chk("rdata1", RDATA1, e_rdata[1]);
    chk("mem_we", 32'(MEM_WE), 32'(e_we));
    chk("mem_addr", MEM_ADDR, e_addr);
    chk("mem_wdata", MEM_WDATA, e_wd);
    granted[0] = GNT0; granted[1] = GNT1;
    acked[0] = ACK0;   acked[1] = ACK1;
    obs_rdata[0] = RDATA0; obs_rdata[1] = RDATA1;
    obs_err[0] = ERR0;     obs_err[1] = ERR1;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input int lat, input string tag);
    int k;
    tb_we[p] = w; tb_addr[p] = a; tb_wdata[p] = d; tb_be[p] = b; tb_req[p] = 1'b1;
    granted[p] = 1'b0;
    k = 0;
    while (!granted[p] && k < 20) begin tick(); k++; end
    if (!granted[p]) chk({tag, "_gnt_timeout"}, 32'(granted[p]), 32'd1);
    tb_req[p] = 1'b0;
    acked[p] = 1'b0;
    k = 0;
    while (!acked[p] && k < 10) begin tick(); k++; end
    chk({tag, "_latency"}, 32'(k), 32'(lat));
  endtask

  task automatic rand_req(input int p);
    int r;
    r = int'($urandom_range(0, 15));
    tb_req[p]   = 1'b1;
    tb_we[p]    = 1'($urandom_range(0, 1));
    tb_wdata[p] = $urandom;
    if (r == 0)      tb_addr[p] = $urandom | 32'h100;
    else if (r < 4)  tb_addr[p] = 32'($urandom_range(0, 255));
    else             tb_addr[p] = 32'($urandom_range(0, 31));
    r = int'($urandom_range(0, 3));
    tb_be[p] = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom_range(0, 15));
  endtask

  int g_seq[8];
  int n_gnt, n_g[2], n_a[2], k;

  initial begin
    cyc = 0;
    for (int p = 0; p < 2; p++) begin
      tb_req[p] = 1'b0; tb_we[p] = 1'b0; tb_addr[p] = '0; tb_wdata[p] = '0; tb_be[p] = '0;
    end
    RESET = 1'b0;
    #2 RESET = 1'b1;
    model_reset();
    #1;
    chk("rst_gnt", 32'({GNT0, GNT1}), 32'd0);
    chk("rst_ack_err", 32'({ACK0, ACK1, ERR0, ERR1}), 32'd0);
    chk("rst_rdata", RDATA0 | RDATA1, 32'd0);
    chk("rst_mem", 32'(MEM_WE) | MEM_ADDR | MEM_WDATA, 32'd0);
    tick(); tick();
    RESET = 1'b0;
    model_reset();

    // full store then load
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, "st_full");
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1, "ld_full");
    chk("ld_deadbeef", obs_rdata[0], 32'hDEADBEEF);
    // partial store via RMW
    do_txn(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 2, "st_part");
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1, "ld_part");
    chk("ld_deadbeaa", obs_rdata[0], 32'hDEADBEAA);
    // out-of-range load and store
    do_txn(1, 1'b0, 32'h100, 32'h0, 4'h0, 1, "ld_oor");
    chk("oor_err", 32'(obs_err[1]), 32'd1);
    chk("oor_rdata", obs_rdata[1], 32'd0);
    do_txn(1, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 1, "st_oor");
    chk("st_oor_err", 32'(obs_err[1]), 32'd1);
    do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 1, "ld_word0");
    chk("word0_untouched", obs_rdata[0], 32'd0);
    // empty store
    do_txn(0, 1'b1, 32'h10, 32'h12345678, 4'h0, 1, "st_empty");
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1, "ld_empty");
    chk("empty_unchanged", obs_rdata[0], 32'hDEADBEAA);

    // reset in the merge cycle of a partial store
    tb_we[0] = 1'b1; tb_addr[0] = 32'h20; tb_wdata[0] = 32'h5555AAAA; tb_be[0] = 4'h3; tb_req[0] = 1'b1;
    granted[0] = 1'b0;
    k = 0;
    while (!granted[0] && k < 20) begin tick(); k++; end
    chk("rmw_rst_gnt", 32'(granted[0]), 32'd1);
    tb_req[0] = 1'b0;
    RESET = 1'b1;
    model_reset();
    #1;
    chk("rmw_rst_ack", 32'(ACK0), 32'd0);
    chk("rmw_rst_we", 32'(MEM_WE), 32'd0);
    tick(); tick();
    RESET = 1'b0;
    model_reset();
    #1;
    chk("post_rst_outs", 32'({GNT0, GNT1, ACK0, ACK1, ERR0, ERR1, MEM_WE}), 32'd0);
    chk("post_rst_data", RDATA0 | RDATA1 | MEM_ADDR | MEM_WDATA, 32'd0);

    // both ports requesting continuously: alternate starting with port 0
    n_gnt = 0; n_g[0] = 0; n_g[1] = 0; n_a[0] = 0; n_a[1] = 0;
    rand_req(0); rand_req(1);
    tb_we[0] = 1'b0; tb_we[1] = 1'b0;
    k = 0;
    while (n_gnt < 8 && k < 60) begin
      tick();
      k++;
      for (int p = 0; p < 2; p++) begin
        if (acked[p]) n_a[p]++;
        if (granted[p]) begin
          if (n_gnt < 8) g_seq[n_gnt] = p;
          n_gnt++;
          n_g[p]++;
          rand_req(p);
        end
      end
    end
    chk("alt_count", 32'(n_gnt), 32'd8);
    for (int i = 0; i < 8; i++) chk("alt_order", 32'(g_seq[i]), 32'(i % 2));
    tb_req[0] = 1'b0; tb_req[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int p = 0; p < 2; p++) if (acked[p]) n_a[p]++;
    end
    chk("alt_ack0", 32'(n_a[0]), 32'(n_g[0]));
    chk("alt_ack1", 32'(n_a[1]), 32'(n_g[1]));

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      tick();
      for (int p = 0; p < 2; p++)
        if (granted[p] || !tb_req[p]) begin
          if ($urandom_range(0, 3) != 0) rand_req(p);
          else tb_req[p] = 1'b0;
        end
    end
    tb_req[0] = 1'b0; tb_req[1] = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 64; i++) chk("mem_final", mem_arr[i], shadow[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
